// File: rtl/sa_inst_queue_if.sv
// rtl/sa_inst_queue_if.sv - sa_inst_t word format and the instruction queue port bundle
//
// Purpose:
//   sa_inst_pkg  : sa_inst_t, the systolic-array vector instruction word.
//   sa_inst_queue_if : groups the queue's host push side, controller pop side
//                  and status outputs into one bundle.
// Port summary (signals inside the interface):
//   flush   host -> queue  synchronous clear of all contents
//   wr_en   host -> queue  push strobe
//   wr_inst host -> queue  instruction to push
//   full / afull / count   queue -> host back-pressure status
//   ovf / udf              queue -> host sticky error flags
//   issued                 queue -> host popped-instruction counter
//   inst / iavail          queue -> vinst_ctl head entry and non-empty flag
//   ird                    vinst_ctl -> queue pop strobe
// Modports:
//   master : the side driving pushes, flush and pops (host + vinst_ctl)
//   slave  : the queue itself

package sa_inst_pkg;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] dst;
    logic [7:0] src;
    logic [7:0] imm;
  } sa_inst_t;

endpackage

interface sa_inst_queue_if #(
  parameter int DEPTH = 8
);
  import sa_inst_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic          flush;
  logic          wr_en;
  sa_inst_t      wr_inst;
  logic          full;
  logic          afull;
  logic [CW-1:0] count;
  sa_inst_t      inst;
  logic          iavail;
  logic          ird;
  logic          ovf;
  logic          udf;
  logic [31:0]   issued;

  modport master (
    output flush, wr_en, wr_inst, ird,
    input  full, afull, count, inst, iavail, ovf, udf, issued
  );

  modport slave (
    input  flush, wr_en, wr_inst, ird,
    output full, afull, count, inst, iavail, ovf, udf, issued
  );

endinterface

// File: rtl/sa_inst_queue.sv
// rtl/sa_inst_queue.sv - buffered instruction queue feeding vinst_ctl
//
// Purpose:
//   DEPTH-entry in-order FIFO of sa_inst_t words. The host pushes with wr_en,
//   vinst_ctl pops with ird while iavail is high. No bypass: a pushed word is
//   visible on inst one cycle after the push edge. Status outputs are decoded
//   from registered state only.
// Ports:
//   clk    : single clock
//   reset  : asynchronous, active-low reset
//   q      : sa_inst_queue_if.slave bundle (flush, wr_en, wr_inst, ird in;
//            full, afull, count, inst, iavail, ovf, udf, issued out)
// Parameters:
//   DEPTH        : number of entries, power of two, >= 2
//   AFULL_THRESH : afull asserts when count >= this value
// Optional feature macro:
//   LAP_IQ_STATS_EN : when defined, issued is a wrapping 32-bit pop counter
//                     cleared only by reset; otherwise issued is tied to 0.

module sa_inst_queue
  import sa_inst_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic               clk,
  input  logic               reset,
  sa_inst_queue_if.slave     q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  sa_inst_t      mem_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic          udf_q,    udf_d;

  logic          full_w;
  logic          avail_w;
  logic          push;
  logic          pop;

  // Status decoded from the count register only.
  assign full_w  = (count_q == CW'(DEPTH));
  assign avail_w = (count_q != '0);

  // A pop frees a slot in the same edge, so a full queue still accepts a push.
  assign pop  = q.ird & avail_w;
  assign push = q.wr_en & (~full_w | pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (q.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
      if (q.wr_en && full_w && !pop) begin
        ovf_d = 1'b1;
      end
      if (q.ird && !avail_w) begin
        udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push && !q.flush) begin
      mem_q[wr_ptr_q] <= q.wr_inst;
    end
  end

`ifdef LAP_IQ_STATS_EN
  logic [31:0] issued_q, issued_d;

  // flush suppresses the pop, so it does not count; the counter itself
  // survives flush and clears only on reset.
  always_comb begin
    issued_d = issued_q;
    if (pop && !q.flush) begin
      issued_d = issued_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued_q <= '0;
    end else begin
      issued_q <= issued_d;
    end
  end

  assign q.issued = issued_q;
`else
  assign q.issued = 32'h0;
`endif

  assign q.full   = full_w;
  assign q.afull  = (count_q >= CW'(AFULL_THRESH));
  assign q.count  = count_q;
  assign q.iavail = avail_w;
  assign q.inst   = mem_q[rd_ptr_q];
  assign q.ovf    = ovf_q;
  assign q.udf    = udf_q;

endmodule

// File: tb/tb_sa_inst_queue.sv
// tb/tb_sa_inst_queue.sv - self-checking bench for sa_inst_queue

module tb_sa_inst_queue;
  import sa_inst_pkg::*;

  localparam int DEPTH = 8;
  localparam int AFULL = DEPTH - 2;

  logic clk;
  logic reset;

  sa_inst_queue_if #(.DEPTH(DEPTH)) qif ();

  sa_inst_queue #(
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .q     (qif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests_run;
  int tests_failed;

  // Reference: a plain queue plus flags, updated from the rules of operation.
  sa_inst_t    mq[$];
  bit          m_ovf;
  bit          m_udf;
  int unsigned m_issued;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic sa_inst_t mk(input logic [7:0] op);
    sa_inst_t w;
    w = sa_inst_t'({op, 24'($urandom)});
    return w;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_issued = 0;
  endfunction

  // Applies one clock edge worth of behaviour using the currently driven inputs.
  function automatic void model_edge();
    int  n;
    bit  is_full;
    bit  has;
    bit  do_pop;
    bit  do_push;
    n       = mq.size();
    is_full = (n == DEPTH);
    has     = (n != 0);
    do_pop  = qif.ird && has;
    do_push = qif.wr_en && (!is_full || do_pop);
    if (qif.flush) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (qif.wr_en && is_full && !do_pop) m_ovf = 1'b1;
      if (qif.ird && !has) m_udf = 1'b1;
      if (do_pop) begin
        void'(mq.pop_front());
        m_issued++;
      end
      if (do_push) mq.push_back(qif.wr_inst);
    end
  endfunction

  task automatic check_all(input string tag);
    logic [31:0] exp_issued;
`ifdef LAP_IQ_STATS_EN
    exp_issued = m_issued;
`else
    exp_issued = 32'h0;
`endif
    check({tag, ".count"},  32'(qif.count), 32'(mq.size()));
    check({tag, ".full"},   32'(qif.full),  32'(mq.size() == DEPTH));
    check({tag, ".afull"},  32'(qif.afull), 32'(mq.size() >= AFULL));
    check({tag, ".iavail"}, 32'(qif.iavail), 32'(mq.size() != 0));
    check({tag, ".ovf"},    32'(qif.ovf),   32'(m_ovf));
    check({tag, ".udf"},    32'(qif.udf),   32'(m_udf));
    check({tag, ".issued"}, qif.issued,     exp_issued);
    if (mq.size() != 0) check({tag, ".inst"}, qif.inst, mq[0]);
  endtask

  task automatic drive(input string tag, input bit we, input sa_inst_t wi, input bit rd, input bit fl);
    qif.wr_en   = we;
    qif.wr_inst = wi;
    qif.ird     = rd;
    qif.flush   = fl;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    drive("idle", 1'b0, mk(8'h00), 1'b0, 1'b0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    qif.wr_en    = 1'b0;
    qif.wr_inst  = '0;
    qif.ird      = 1'b0;
    qif.flush    = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;
    idle();

    // Three pushes, then three pops with ird held high.
    drive("push_a1", 1'b1, mk(8'hA1), 1'b0, 1'b0);
    drive("push_a2", 1'b1, mk(8'hA2), 1'b0, 1'b0);
    drive("push_a3", 1'b1, mk(8'hA3), 1'b0, 1'b0);
    check("head_is_a1", 32'(qif.inst.opcode), 32'hA1);
    drive("pop1", 1'b0, mk(8'h00), 1'b1, 1'b0);
    check("head_is_a2", 32'(qif.inst.opcode), 32'hA2);
    drive("pop2", 1'b0, mk(8'h00), 1'b1, 1'b0);
    check("head_is_a3", 32'(qif.inst.opcode), 32'hA3);
    drive("pop3", 1'b0, mk(8'h00), 1'b1, 1'b0);

    // Fill to DEPTH, then overflow attempt.
    for (int i = 0; i < DEPTH; i++) drive("fill", 1'b1, mk(8'h10 + 8'(i)), 1'b0, 1'b0);
    check("full_at_depth", 32'(qif.full), 32'h1);
    drive("push9", 1'b1, mk(8'hEE), 1'b0, 1'b0);
    check("ovf_after_push9", 32'(qif.ovf), 32'h1);

    // Clear ovf, refill, then concurrent push/pop at full.
    drive("flush_a", 1'b0, mk(8'h00), 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) drive("refill", 1'b1, mk(8'h20 + 8'(i)), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive("full_pp", 1'b1, mk(8'h30 + 8'(i)), 1'b1, 1'b0);
    check("head_after_pp", 32'(qif.inst.opcode), 32'h24);
    for (int i = 0; i < DEPTH; i++) drive("drain", 1'b0, mk(8'h00), 1'b1, 1'b0);

    // Underflow, then push with simultaneous ird on an empty queue.
    drive("udf", 1'b0, mk(8'h00), 1'b1, 1'b0);
    drive("push55", 1'b1, mk(8'h55), 1'b1, 1'b0);
    check("head_is_55", 32'(qif.inst.opcode), 32'h55);

    // Reach count 5, then flush with push and pop also requested.
    for (int i = 0; i < 4; i++) drive("to5", 1'b1, mk(8'h40 + 8'(i)), 1'b0, 1'b0);
    drive("flush_all", 1'b1, mk(8'h66), 1'b1, 1'b1);
    check("count_after_flush", 32'(qif.count), 32'h0);

    // count 4 with ovf set, then asynchronous reset mid-cycle.
    for (int i = 0; i < DEPTH; i++) drive("fill2", 1'b1, mk(8'h50 + 8'(i)), 1'b0, 1'b0);
    drive("ovf2", 1'b1, mk(8'hEF), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive("to4", 1'b0, mk(8'h00), 1'b1, 1'b0);
    qif.wr_en = 1'b0;
    qif.ird   = 1'b0;
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("in_rst");
    reset = 1'b1;
    drive("post_p1", 1'b1, mk(8'h71), 1'b0, 1'b0);
    drive("post_p2", 1'b1, mk(8'h72), 1'b0, 1'b0);
    drive("post_r1", 1'b0, mk(8'h00), 1'b1, 1'b0);
    drive("post_r2", 1'b0, mk(8'h00), 1'b1, 1'b0);

    // Randomized traffic with alternating fill/drain bias and rare flushes.
    for (int seg = 0; seg < 16; seg++) begin
      int wp;
      int rp;
      wp = (seg % 2 == 0) ? 80 : 30;
      rp = (seg % 2 == 0) ? 35 : 85;
      for (int c = 0; c < 100; c++) begin
        drive("rand",
              $urandom_range(0, 99) < wp,
              sa_inst_t'($urandom),
              $urandom_range(0, 99) < rp,
              $urandom_range(0, 63) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
